// File: rtl/alu_input_ctrl_if.sv
// Board-side bundle between the switches/buttons and the ALU operand/command inputs.
interface alu_input_ctrl_if #(
  parameter int N = 4
);
  logic [N-1:0] sw;
  logic         btn_load_raw;
  logic         btn_mode_raw;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic [2:0]   mode;
  logic         click;
  logic         valid;
  logic [1:0]   state;

  modport master (
    output sw, btn_load_raw, btn_mode_raw,
    input  in1, in2, mode, click, valid, state
  );

  modport slave (
    input  sw, btn_load_raw, btn_mode_raw,
    output in1, in2, mode, click, valid, state
  );
endinterface

// File: rtl/alu_input_ctrl.sv
// Debounces the load/mode buttons, sequences operand capture A -> B -> READY,
// and steps the ALU mode with a one-cycle click on every mode press.
module alu_input_ctrl #(
  parameter int N         = 4,
  parameter int DB_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  alu_input_ctrl_if.slave bus
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    READY  = 2'd2
  } state_e;

  // Index 0 is the load button, index 1 the mode button.
  logic [1:0]    raw;
  logic [1:0]    s1_q, s2_q, db_q, dbl_q, p_q;
  logic [CW-1:0] cnt_q [2];

  state_e        state_q;
  logic [N-1:0]  in1_q, in2_q;
  logic [2:0]    mode_q;
  logic          click_q, valid_q;
  logic          pl, pm;

  assign raw = {bus.btn_mode_raw, bus.btn_load_raw};
  assign pl  = p_q[0];
  assign pm  = p_q[1];

  // Edge pulse is taken from the registered debounced level, so it trails db by one edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        s1_q[i]  <= 1'b0;
        s2_q[i]  <= 1'b0;
        db_q[i]  <= 1'b0;
        dbl_q[i] <= 1'b0;
        p_q[i]   <= 1'b0;
        cnt_q[i] <= '0;
      end else begin
        s1_q[i]  <= raw[i];
        s2_q[i]  <= s1_q[i];
        dbl_q[i] <= db_q[i];
        p_q[i]   <= db_q[i] & ~dbl_q[i];
        if (s2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          db_q[i]  <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      in1_q   <= '0;
      in2_q   <= '0;
      valid_q <= 1'b0;
      mode_q  <= 3'd0;
      click_q <= 1'b0;
    end else begin
      if (pl) begin
        case (state_q)
          LOAD_A: begin
            in1_q   <= bus.sw;
            state_q <= LOAD_B;
          end
          LOAD_B: begin
            in2_q   <= bus.sw;
            valid_q <= 1'b1;
            state_q <= READY;
          end
          READY: begin
            valid_q <= 1'b0;
            state_q <= LOAD_A;
          end
          default: begin
            valid_q <= 1'b0;
            state_q <= LOAD_A;
          end
        endcase
      end
      click_q <= pm;
      if (pm) mode_q <= mode_q + 3'd1;
    end
  end

  assign bus.in1   = in1_q;
  assign bus.in2   = in2_q;
  assign bus.mode  = mode_q;
  assign bus.click = click_q;
  assign bus.valid = valid_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Directed bench for alu_input_ctrl with DB_CYCLES=4 and N=4.
module tb_alu_input_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   clicks = 0;

  alu_input_ctrl_if #(.N(4)) bus ();

  alu_input_ctrl #(.N(4), .DB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Running count of click-high cycles, sampled mid-cycle.
  always @(negedge clk) if (bus.click === 1'b1) clicks++;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.btn_load_raw = 1'b0;
    bus.btn_mode_raw = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic press_load(input logic [3:0] v);
    bus.sw = v;
    bus.btn_load_raw = 1'b1;
    tick(10);
    bus.btn_load_raw = 1'b0;
    tick(12);
  endtask

  task automatic press_mode();
    bus.btn_mode_raw = 1'b1;
    tick(10);
    bus.btn_mode_raw = 1'b0;
    tick(12);
  endtask

  task automatic test_reset();
    int c0;
    bus.sw = 4'h0;
    bus.btn_load_raw = 1'b1;
    bus.btn_mode_raw = 1'b1;
    rst = 1'b1;
    tick(2);
    n_vec++; if (bus.in1 !== 4'h0) begin n_err++; $display("FAIL reset_in1 got %h want 0", bus.in1); end
    n_vec++; if (bus.in2 !== 4'h0) begin n_err++; $display("FAIL reset_in2 got %h want 0", bus.in2); end
    n_vec++; if (bus.mode !== 3'd0) begin n_err++; $display("FAIL reset_mode got %0d want 0", bus.mode); end
    n_vec++; if (bus.click !== 1'b0) begin n_err++; $display("FAIL reset_click got %b want 0", bus.click); end
    n_vec++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    n_vec++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", bus.state); end
    c0 = clicks;
    rst = 1'b0;
    tick(7);
    n_vec++; if (bus.click !== 1'b0) begin n_err++; $display("FAIL held_click_early got %b want 0", bus.click); end
    tick(1);
    n_vec++; if (bus.click !== 1'b1 || bus.mode !== 3'd1) begin n_err++; $display("FAIL held_click_edge got click=%b mode=%0d want click=1 mode=1", bus.click, bus.mode); end
    tick(12);
    n_vec++; if (clicks - c0 !== 1) begin n_err++; $display("FAIL held_click_count got %0d want 1", clicks - c0); end
    n_vec++; if (bus.state !== 2'd1 || bus.mode !== 3'd1) begin n_err++; $display("FAIL held_after got state=%0d mode=%0d want state=1 mode=1", bus.state, bus.mode); end
    bus.btn_load_raw = 1'b0;
    bus.btn_mode_raw = 1'b0;
    tick(12);
  endtask

  task automatic test_glitch();
    int c0;
    do_reset();
    c0 = clicks;
    bus.btn_mode_raw = 1'b1;
    tick(3);
    bus.btn_mode_raw = 1'b0;
    tick(12);
    n_vec++; if (clicks - c0 !== 0 || bus.mode !== 3'd0) begin n_err++; $display("FAIL glitch_reject got clicks=%0d mode=%0d want 0/0", clicks - c0, bus.mode); end
    bus.btn_mode_raw = 1'b1;
    tick(7);
    n_vec++; if (bus.click !== 1'b0 || bus.mode !== 3'd0) begin n_err++; $display("FAIL debounce_early got click=%b mode=%0d want 0/0", bus.click, bus.mode); end
    tick(1);
    n_vec++; if (bus.click !== 1'b1 || bus.mode !== 3'd1) begin n_err++; $display("FAIL debounce_edge got click=%b mode=%0d want 1/1", bus.click, bus.mode); end
    tick(1);
    n_vec++; if (bus.click !== 1'b0) begin n_err++; $display("FAIL click_width got %b want 0", bus.click); end
    tick(1);
    bus.btn_mode_raw = 1'b0;
    tick(12);
    n_vec++; if (clicks - c0 !== 1 || bus.mode !== 3'd1) begin n_err++; $display("FAIL hold_release got clicks=%0d mode=%0d want 1/1", clicks - c0, bus.mode); end
  endtask

  task automatic test_operand_load();
    do_reset();
    press_load(4'hA);
    n_vec++; if (bus.state !== 2'd1 || bus.in1 !== 4'hA || bus.valid !== 1'b0) begin n_err++; $display("FAIL load_a got state=%0d in1=%h valid=%b want 1/a/0", bus.state, bus.in1, bus.valid); end
    press_load(4'h3);
    n_vec++; if (bus.state !== 2'd2 || bus.in2 !== 4'h3 || bus.valid !== 1'b1 || bus.in1 !== 4'hA) begin n_err++; $display("FAIL load_b got state=%0d in1=%h in2=%h valid=%b want 2/a/3/1", bus.state, bus.in1, bus.in2, bus.valid); end
    press_load(4'hF);
    n_vec++; if (bus.state !== 2'd0 || bus.valid !== 1'b0 || bus.in1 !== 4'hA || bus.in2 !== 4'h3) begin n_err++; $display("FAIL load_ready got state=%0d in1=%h in2=%h valid=%b want 0/a/3/0", bus.state, bus.in1, bus.in2, bus.valid); end
  endtask

  task automatic test_mode_wrap();
    int c0;
    logic [2:0] exp_mode;
    do_reset();
    c0 = clicks;
    for (int i = 0; i < 8; i++) begin
      press_mode();
      exp_mode = 3'(i + 1);
      n_vec++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL mode_step%0d got %0d want %0d", i, bus.mode, exp_mode); end
    end
    n_vec++; if (clicks - c0 !== 8) begin n_err++; $display("FAIL mode_clicks got %0d want 8", clicks - c0); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press_load(4'h1);
    for (int i = 0; i < 5; i++) press_mode();
    bus.sw = 4'h6;
    bus.btn_load_raw = 1'b1;
    bus.btn_mode_raw = 1'b1;
    tick(7);
    n_vec++; if (bus.in2 !== 4'h0 || bus.mode !== 3'd5 || bus.valid !== 1'b0) begin n_err++; $display("FAIL simul_early got in2=%h mode=%0d valid=%b want 0/5/0", bus.in2, bus.mode, bus.valid); end
    tick(1);
    n_vec++; if (bus.in2 !== 4'h6 || bus.valid !== 1'b1 || bus.mode !== 3'd6 || bus.click !== 1'b1 || bus.state !== 2'd2) begin n_err++; $display("FAIL simul_edge got in2=%h valid=%b mode=%0d click=%b state=%0d want 6/1/6/1/2", bus.in2, bus.valid, bus.mode, bus.click, bus.state); end
    bus.btn_load_raw = 1'b0;
    bus.btn_mode_raw = 1'b0;
    tick(12);
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    press_load(4'h9);
    n_vec++; if (bus.in1 !== 4'h9 || bus.state !== 2'd1) begin n_err++; $display("FAIL midload_setup got in1=%h state=%0d want 9/1", bus.in1, bus.state); end
    bus.sw = 4'h5;
    bus.btn_load_raw = 1'b1;
    tick(4);
    rst = 1'b1;
    bus.btn_load_raw = 1'b0;
    tick(1);
    rst = 1'b0;
    n_vec++; if (bus.state !== 2'd0 || bus.in1 !== 4'h0) begin n_err++; $display("FAIL midload_reset got state=%0d in1=%h want 0/0", bus.state, bus.in1); end
    tick(15);
    n_vec++; if (bus.state !== 2'd0 || bus.in1 !== 4'h0 || bus.in2 !== 4'h0) begin n_err++; $display("FAIL midload_after got state=%0d in1=%h in2=%h want 0/0/0", bus.state, bus.in1, bus.in2); end
  endtask

  initial begin
    bus.sw = 4'h0;
    bus.btn_load_raw = 1'b0;
    bus.btn_mode_raw = 1'b0;
    test_reset();
    test_glitch();
    test_operand_load();
    test_mode_wrap();
    test_simultaneous();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_input_ctrl.md
Name: alu_input_ctrl

Overview:
- Front-end controller that generates the operand and command side of the ALU interface from raw board switches and push-buttons.
- Debounces two raw buttons and sequences operand capture (A, then B, then ready) through a small FSM.
- Holds the operation mode and issues a single-cycle click pulse to the ALU on every mode change.
- Sits between the board I/O pins and the ALU's in1/in2/click inputs.

Parameters:
- N, 4, operand width in bits (matches ALU n).
- DB_CYCLES, 4, consecutive cycles a synchronized button level must differ from the debounced level before the debounced level flips; legal range >= 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  N  raw operand switches; sampled only on a load event.
- btn_load_raw  input  1  raw asynchronous load button, active high.
- btn_mode_raw  input  1  raw asynchronous mode button, active high.
- in1  output  N  captured operand A.
- in2  output  N  captured operand B.
- mode  output  3  current operation code, 0..7.
- click  output  1  one-cycle pulse on each mode advance.
- valid  output  1  high while both operands are captured (state READY).
- state  output  2  FSM state: 0 LOAD_A, 1 LOAD_B, 2 READY.

Behaviour:
- Clock and reset: single clock domain clk. Reset rst is synchronous and active-high; it takes effect on the rising edge of clk where rst=1.
- Reset values: in1=0, in2=0, mode=0, click=0, valid=0, state=LOAD_A. All synchronizer flops, debounce counters and debounced levels are 0.
- Per-button debouncer (two identical instances):
  - 2-flop synchronizer s1 -> s2.
  - Counter cnt counts while s2 != db and clears to 0 whenever s2 == db.
  - When cnt == DB_CYCLES-1 and s2 != db: db <= s2 and cnt <= 0.
  - Rising-edge pulse p <= db_next & ~db, registered.
- Debounce timing: let raw be high and stable, first sampled at edge k. Then db rises at edge k+DB_CYCLES+1 and p is high for exactly one cycle after edge k+DB_CYCLES+2.
- Debounce filtering:
  - A raw glitch shorter than DB_CYCLES synchronized cycles produces no pulse.
  - Release is debounced identically but produces no pulse.
  - Holding a button produces exactly one pulse.
- FSM (advances on load pulse pl only):
  - LOAD_A + pl: in1 <= sw, go to LOAD_B.
  - LOAD_B + pl: in2 <= sw, go to READY, valid <= 1 on the same edge.
  - READY + pl: valid <= 0, go to LOAD_A. in1/in2 hold their old values until recaptured; sw is not sampled on this transition.
  - No pl: state, in1, in2 and valid hold.
- Mode (on mode pulse pm, in any FSM state):
  - mode <= mode+1, wrapping 7 -> 0.
  - click <= 1 for exactly that one cycle, aligned with the mode update edge.
- Simultaneous pl and pm in the same cycle: both actions occur independently on the same edge.
- Reset mid-operation: an active debounce count, a pending pulse or a partial load is discarded.
- Button held through reset release: db restarts at 0, so a held button yields one pulse DB_CYCLES+2 edges after the first post-reset edge.
- Outputs are all registered. There is no combinational path from any input to any output.

Test Plan:
- Reset: assert rst for 2 cycles with both buttons held high -> in1=0, in2=0, mode=0, click=0, valid=0, state=0. After release, exactly one click pulse and mode=1 once debounce completes.
- Glitch rejection (DB_CYCLES=4): btn_mode_raw high for 3 cycles then low -> no click, mode stays 0. Then high for 10 cycles -> exactly one click, asserted one cycle after edge k+6, mode=1.
- Operand load: sw=4'hA, press load; sw=4'h3, press load -> in1=0xA, in2=0x3, valid=1, state=2. Press load again with sw=4'hF -> valid=0, state=0, in1 still 0xA.
- Mode wrap: 8 separate mode presses from reset -> mode steps 1..7 then 0, with 8 single-cycle click pulses.
- Simultaneous: in LOAD_B with mode=5, both buttons rise on the same cycle with sw=4'h6 -> on one edge in2=0x6, valid=1, mode=6, click=1.
- Reset mid-load: in LOAD_B with in1=0x9, assert rst for 1 cycle during a load debounce -> state=0, in1=0, no load pulse afterwards unless the button is still held.
